// File: rtl/store_commit_buffer.sv
// store_commit_buffer
//   In-order store buffer on the write side of the data-memory path. Issued
//   SB/SH/SW stores are accepted from the reservation station, held
//   speculatively and reported done to the ROB. Stores are written to data
//   memory only after the ROB commits them. A mispredict discards younger
//   uncommitted entries, and load probes are flagged when they alias a
//   pending store word.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   st_*                  issued store in (valid/tag/func3/base/imm/data),
//                         st_ready out, st_done/st_done_tag completion pulse
//   commit_valid/_tag     ROB retiring a store
//   mispredict/_tag,      branch flush; kill range is
//   curr_rob_tag          (mispredict_tag, curr_rob_tag) modulo ROB_SIZE
//   mem_we/addr/wdata/be  data-memory write request, held until mem_ack
//   ld_check/ld_addr      load alias probe -> ld_conflict (combinational)
//   empty, full           occupancy flags
module store_commit_buffer #(
  parameter int DEPTH    = 8,
  parameter int ROB_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [4:0]  st_rob_tag,
  input  logic [2:0]  st_func3,
  input  logic [31:0] st_base,
  input  logic [31:0] st_imm,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic [4:0]  st_done_tag,
  input  logic        commit_valid,
  input  logic [4:0]  commit_tag,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  input  logic [4:0]  curr_rob_tag,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  // Control state (reset)
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             st_done_q, st_done_d;
  logic [4:0]       st_done_tag_q, st_done_tag_d;

  // Entry payload (not reset; only meaningful while the valid bit is set)
  logic [4:0]  tag_q   [DEPTH];
  logic [29:0] addr_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];

  // Write FSM and registered memory outputs
  state_t      state_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;

  // Incoming store decode
  logic [31:0]      eff_addr;
  logic [3:0]       push_be;
  logic [31:0]      push_wdata;
  logic             push_en;
  logic [PTR_W-1:0] push_idx;
  logic             pop;

  // Scratch for the next-state scan
  logic             found;
  logic [PTR_W-1:0] idx;
  logic [CNT_W-1:0] last;

  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

  // Circular membership test: tag lies in (mt, ct) modulo ROB_SIZE.
  function automatic logic in_kill(input logic [4:0] t, input logic [4:0] mt,
                                   input logic [4:0] ct);
    int off;
    int len;
    off = (int'(t)  + 2 * ROB_SIZE - int'(mt) - 1) % ROB_SIZE;
    len = (int'(ct) + 2 * ROB_SIZE - int'(mt) - 1) % ROB_SIZE;
    return off < len;
  endfunction

  assign st_ready    = (count_q != CNT_W'(DEPTH));
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign st_done     = st_done_q;
  assign st_done_tag = st_done_tag_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;

  assign pop = (state_q == WRITE) && mem_ack;

  always_comb begin
    eff_addr   = st_base + st_imm;
    push_be    = 4'b1111;
    push_wdata = st_data;
    case (st_func3)
      3'b000: begin
        push_be    = 4'b0001 << eff_addr[1:0];
        push_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        push_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        push_wdata = {2{st_data[15:0]}};
      end
      default: begin
        push_be    = 4'b1111;
        push_wdata = st_data;
      end
    endcase
  end

  // Next state: commit, then mispredict rollback, then pop, then push.
  always_comb begin
    vld_d         = vld_q;
    cmt_d         = cmt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    found         = 1'b0;
    idx           = '0;
    last          = '0;
    push_en       = 1'b0;
    push_idx      = '0;
    st_done_d     = 1'b0;
    st_done_tag_d = st_done_tag_q;

    // Only the oldest uncommitted entry may be committed.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (i < int'(count_q) && !found && vld_q[idx] && !cmt_q[idx]) begin
        found = 1'b1;
        if (commit_valid && tag_q[idx] == commit_tag) cmt_d[idx] = 1'b1;
      end
    end

    // Stores are in program order, so killed entries form the young suffix;
    // the tail lands just past the youngest survivor.
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if (i < int'(count_q)) begin
          if (vld_d[idx] && !cmt_d[idx] &&
              in_kill(tag_q[idx], mispredict_tag, curr_rob_tag)) begin
            vld_d[idx] = 1'b0;
          end else if (vld_d[idx]) begin
            last = CNT_W'(i + 1);
          end
        end
      end
      count_d = last;
      tail_d  = head_q + last[PTR_W-1:0];
    end

    if (pop) begin
      vld_d[head_q] = 1'b0;
      cmt_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
      count_d       = count_d - 1'b1;
    end

    push_en = st_valid && st_ready &&
              !(mispredict && in_kill(st_rob_tag, mispredict_tag, curr_rob_tag));
    push_idx = tail_d;
    if (push_en) begin
      vld_d[tail_d] = 1'b1;
      cmt_d[tail_d] = 1'b0;
      tail_d        = tail_d + 1'b1;
      count_d       = count_d + 1'b1;
      st_done_d     = 1'b1;
      st_done_tag_d = st_rob_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q         <= '0;
      cmt_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      st_done_q     <= 1'b0;
      st_done_tag_q <= '0;
    end else begin
      vld_q         <= vld_d;
      cmt_q         <= cmt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      st_done_q     <= st_done_d;
      st_done_tag_q <= st_done_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      tag_q[push_idx]   <= st_rob_tag;
      addr_q[push_idx]  <= eff_addr[31:2];
      wdata_q[push_idx] <= push_wdata;
      be_q[push_idx]    <= push_be;
    end
  end

  // Write FSM: WRITE always returns to IDLE, so writes are at most 1 per 2 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vld_q[head_q] && cmt_q[head_q]) begin
            mem_addr_q  <= {addr_q[head_q], 2'b00};
            mem_wdata_q <= wdata_q[head_q];
            mem_be_q    <= be_q[head_q];
            mem_we_q    <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_we_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_check && vld_q[i] && addr_q[i] == ld_addr[31:2]) ld_conflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [4:0]  st_rob_tag;
  logic [2:0]  st_func3;
  logic [31:0] st_base;
  logic [31:0] st_imm;
  logic [31:0] st_data;
  logic        st_done;
  logic [4:0]  st_done_tag;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [4:0]  curr_rob_tag;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  store_commit_buffer #(.DEPTH(8), .ROB_SIZE(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_rob_tag     (st_rob_tag),
    .st_func3       (st_func3),
    .st_base        (st_base),
    .st_imm         (st_imm),
    .st_data        (st_data),
    .st_done        (st_done),
    .st_done_tag    (st_done_tag),
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .curr_rob_tag   (curr_rob_tag),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .ld_check       (ld_check),
    .ld_addr        (ld_addr),
    .ld_conflict    (ld_conflict),
    .empty          (empty),
    .full           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] tag, input logic [2:0] f3,
                      input logic [31:0] base, input logic [31:0] imm,
                      input logic [31:0] data);
    st_valid   = 1'b1;
    st_rob_tag = tag;
    st_func3   = f3;
    st_base    = base;
    st_imm     = imm;
    st_data    = data;
    tick();
    st_valid   = 1'b0;
  endtask

  task automatic commit(input logic [4:0] tag);
    commit_valid = 1'b1;
    commit_tag   = tag;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] a, input logic exp);
    ld_check = 1'b1;
    ld_addr  = a;
    #1;
    chk(tag, 32'(ld_conflict), 32'(exp));
    ld_check = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 0; st_rob_tag = 0; st_func3 = 0; st_base = 0;
    st_imm = 0; st_data = 0; commit_valid = 0; commit_tag = 0; mispredict = 0;
    mispredict_tag = 0; curr_rob_tag = 0; mem_ack = 0; ld_check = 0; ld_addr = 0;

    repeat (2) tick();
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_st_done", 32'(st_done), 32'd0);
    chk("rst_st_done_tag", 32'(st_done_tag), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_ld_conflict", 32'(ld_conflict), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    tick();

    // SW 0x100+4, tag 3
    push(5'd3, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF);
    chk("sw_done", 32'(st_done), 32'd1);
    chk("sw_done_tag", 32'(st_done_tag), 32'd3);
    chk("sw_not_empty", 32'(empty), 32'd0);
    tick();
    chk("sw_done_pulse", 32'(st_done), 32'd0);
    commit(5'd3);
    chk("sw_we_edge1", 32'(mem_we), 32'd0);
    tick();
    chk("sw_we", 32'(mem_we), 32'd1);
    chk("sw_addr", mem_addr, 32'h104);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_be", 32'(mem_be), 32'hF);
    tick();
    chk("sw_we_held", 32'(mem_we), 32'd1);
    chk("sw_addr_held", mem_addr, 32'h104);
    ack();
    chk("sw_we_drop", 32'(mem_we), 32'd0);
    chk("sw_empty", 32'(empty), 32'd1);

    // SB at 0x203, SH at 0x202
    push(5'd4, 3'b000, 32'h200, 32'd3, 32'h123456AB);
    chk("sb_done_tag", 32'(st_done_tag), 32'd4);
    push(5'd5, 3'b001, 32'h200, 32'd2, 32'hFFFF1234);
    chk("sh_done_tag", 32'(st_done_tag), 32'd5);
    commit(5'd4);
    commit(5'd5);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_be", 32'(mem_be), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    ack();
    chk("sb_we_drop", 32'(mem_we), 32'd0);
    tick();
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    ack();
    chk("sh_empty", 32'(empty), 32'd1);

    // Fill to DEPTH
    for (int i = 0; i < 8; i++) push(5'(i), 3'b010, 32'h400, 32'(4 * i), 32'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(st_ready), 32'd0);
    push(5'd8, 3'b010, 32'h800, 32'd0, 32'h8);
    chk("fill_9th_no_done", 32'(st_done), 32'd0);
    commit(5'd0);
    tick();
    chk("fill_we", 32'(mem_we), 32'd1);
    chk("fill_addr", mem_addr, 32'h400);
    chk("fill_ready_wr", 32'(st_ready), 32'd0);
    ack();
    chk("fill_ready_after", 32'(st_ready), 32'd1);
    chk("fill_full_after", 32'(full), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("fill_reset_empty", 32'(empty), 32'd1);

    // Mispredict: tags 2..5, tag 2 committed, kill (3,6)
    push(5'd2, 3'b010, 32'h500, 32'd0, 32'h22);
    push(5'd3, 3'b010, 32'h504, 32'd0, 32'h33);
    push(5'd4, 3'b010, 32'h508, 32'd0, 32'h44);
    push(5'd5, 3'b010, 32'h50C, 32'd0, 32'h55);
    commit(5'd2);
    mispredict = 1'b1; mispredict_tag = 5'd3; curr_rob_tag = 5'd6;
    tick();
    mispredict = 1'b0;
    chk("mp_we_tag2", 32'(mem_we), 32'd1);
    chk("mp_addr_tag2", mem_addr, 32'h500);
    probe("mp_ld_tag4_killed", 32'h508, 1'b0);
    probe("mp_ld_tag5_killed", 32'h50C, 1'b0);
    probe("mp_ld_tag3_alive", 32'h504, 1'b1);
    ack();
    push(5'd6, 3'b010, 32'h600, 32'd0, 32'h66);
    chk("mp_new_done_tag", 32'(st_done_tag), 32'd6);
    commit(5'd9);
    tick();
    chk("mp_tag3_waits", 32'(mem_we), 32'd0);
    commit(5'd3);
    tick();
    chk("mp_tag3_we", 32'(mem_we), 32'd1);
    chk("mp_tag3_addr", mem_addr, 32'h504);
    ack();
    commit(5'd6);
    tick();
    chk("mp_tag6_addr", mem_addr, 32'h600);
    chk("mp_tag6_wdata", mem_wdata, 32'h66);
    ack();
    chk("mp_empty", 32'(empty), 32'd1);

    // Load alias probe
    push(5'd7, 3'b010, 32'h300, 32'd0, 32'h77);
    probe("ld_302_hit", 32'h302, 1'b1);
    probe("ld_304_miss", 32'h304, 1'b0);
    ld_addr = 32'h300;
    #1;
    chk("ld_no_check", 32'(ld_conflict), 32'd0);
    commit(5'd7);
    tick();
    ack();
    probe("ld_302_after", 32'h302, 1'b0);

    // Reset during a write
    push(5'd8, 3'b010, 32'h700, 32'd0, 32'h88);
    commit(5'd8);
    tick();
    chk("rw_we_before", 32'(mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we_async", 32'(mem_we), 32'd0);
    chk("rw_empty", 32'(empty), 32'd1);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("rw_no_write", 32'(mem_we), 32'd0);
    chk("rw_addr", mem_addr, 32'd0);

    // Push dropped by a same-cycle mispredict
    st_valid = 1'b1; st_rob_tag = 5'd10; st_func3 = 3'b010; st_base = 32'h900;
    st_imm = 0; mispredict = 1'b1; mispredict_tag = 5'd9; curr_rob_tag = 5'd11;
    tick();
    st_valid = 1'b0; mispredict = 1'b0;
    chk("drop_no_done", 32'(st_done), 32'd0);
    chk("drop_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
